// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath: product width,
// accumulator FSM states and signed range helpers.
package booth_pkg;

    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic signed [63:0] ACC_MAX(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] ACC_MIN(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed adder with overflow detect. Clamps to the
// representable range when SATURATE_EN is defined, otherwise wraps.
import booth_pkg::*;

module booth_sat_add #(
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    overflow
);

`ifdef SATURATE_EN
    localparam logic signed [63:0]      MAX_WIDE = ACC_MAX(ACC_W);
    localparam logic signed [63:0]      MIN_WIDE = ACC_MIN(ACC_W);
    localparam logic signed [ACC_W-1:0] MAX_V    = MAX_WIDE[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] MIN_V    = MIN_WIDE[ACC_W-1:0];
`endif

    logic signed [ACC_W-1:0] raw;

    // Overflow only when both addends share a sign the raw result lacks.
    always_comb begin
        raw      = a + b;
        overflow = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef SATURATE_EN
        if (overflow) begin
            sum = a[ACC_W-1] ? MIN_V : MAX_V;
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums LEN signed Booth products into an ACC_W result with a valid/ready
// output and sticky overflow. Saturating arithmetic under SATURATE_EN.
module booth_dot_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN   = 4,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Clear,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic signed [PROD_W-1:0] Product,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic signed [ACC_W-1:0]  Acc_Out,
    output logic                     Overflow,
    output logic [CNT_W-1:0]         Term_Count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    state_t                  state;
    state_t                  next_state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext_product;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;
    logic                    sticky;
    logic                    accept;
    logic                    last_term;

    assign ext_product = ACC_W'(Product);
    assign accept      = In_Ready && In_Valid;
    assign last_term   = (Term_Count == LAST_IDX);

    booth_sat_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .a       (acc),
        .b       (ext_product),
        .sum     (sum),
        .overflow(add_ovf)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs decode the state register only.
    always_comb begin
        next_state = state;
        In_Ready   = 1'b0;
        Out_Valid  = 1'b0;
        case (state)
            ACCUM: begin
                In_Ready = 1'b1;
                if (!Clear && In_Valid && last_term) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                Out_Valid = 1'b1;
                if (Clear || Out_Ready) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    // Acc_Out and Overflow only change on reset or a final accept.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc        <= '0;
            Term_Count <= '0;
            sticky     <= 1'b0;
            Acc_Out    <= '0;
            Overflow   <= 1'b0;
        end else if (Clear) begin
            acc        <= '0;
            Term_Count <= '0;
            sticky     <= 1'b0;
        end else if (accept) begin
            acc        <= sum;
            Term_Count <= Term_Count + CNT_W'(1);
            sticky     <= sticky | add_ovf;
            if (last_term) begin
                Acc_Out  <= sum;
                Overflow <= sticky | add_ovf;
            end
        end else if (Out_Valid && Out_Ready) begin
            acc        <= '0;
            Term_Count <= '0;
            sticky     <= 1'b0;
        end
    end

endmodule
